// File: rtl/fetch_queue.sv
// fetch_queue: show-ahead circular FIFO of {address, instruction} pairs between fetch and decode.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-low
//   flush      synchronous discard of all entries (wins over push/pop)
//   in_valid   fetch presents {in_addr, in_instr}
//   in_ready   queue can accept a word (count != DEPTH)
//   out_valid  head entry is valid (count != 0)
//   out_ready  decode consumes the head
//   out_addr   address of the head entry
//   out_instr  instruction of the head entry
//   count      occupied entries, 0..DEPTH
module fetch_queue #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDR_W-1:0]      in_addr,
  input  logic [DATA_W-1:0]      in_instr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDR_W-1:0]      out_addr,
  output logic [DATA_W-1:0]      out_instr,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  logic [ADDR_W-1:0] addr_mem  [DEPTH];
  logic [DATA_W-1:0] instr_mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic              push, pop;
  // Ready/valid depend only on registered count, so a pop never opens a push slot in the same cycle.
  assign in_ready  = count != (PW+1)'(DEPTH);
  assign out_valid = count != '0;
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign out_addr  = addr_mem[rd_ptr];
  assign out_instr = instr_mem[rd_ptr];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem[i]  <= '0;
        instr_mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        addr_mem[wr_ptr]  <= in_addr;
        instr_mem[wr_ptr] <= in_instr;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
endmodule
